// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU and result/flag register.
// Optional response watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int OPW     = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             reg_en,
    input  logic [WIDTH-1:0] reg_q,
    input  logic             reg_c,
    input  logic             reg_ovf,
    input  logic             reg_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_c,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    output logic             rsp_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           r_state;
    logic             r_ptr;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic             r_reg_en;
    logic             r_rsp_valid;
    logic             r_timeout;

    logic w_idle;
    logic w_grant1;
    logic w_accept;

    // Ready is combinational, so it must also be forced low while in reset.
    assign w_idle   = (r_state == S_IDLE) && !rst;
    assign w_grant1 = req1_valid && (!req0_valid || r_ptr);
    assign w_accept = req0_valid || req1_valid;

    assign req0_ready = w_idle && req0_valid && !w_grant1;
    assign req1_ready = w_idle && w_grant1;

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_op      = r_op;
    assign reg_en      = r_reg_en;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_id;
    assign rsp_data    = r_rsp_valid ? reg_q : '0;
    assign rsp_c       = r_rsp_valid && reg_c;
    assign rsp_ovf     = r_rsp_valid && reg_ovf;
    assign rsp_zero    = r_rsp_valid && reg_zero;
    assign rsp_timeout = r_timeout;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_reg_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id     <= w_grant1;
                        r_a      <= w_grant1 ? req1_a : req0_a;
                        r_b      <= w_grant1 ? req1_b : req0_b;
                        r_op     <= w_grant1 ? req1_op : req0_op;
                        r_reg_en <= 1'b1;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_reg_en    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
`ifdef ALU_ARB_TIMEOUT_EN
                    r_cnt       <= '0;
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= ~r_id;
                        r_state     <= S_IDLE;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= ~r_id;
                        r_timeout   <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter with a behavioural ALU/result register.
// Define ALU_ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]   req0_op, req1_op;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [OPW-1:0]   alu_op;
    logic             reg_en;
    logic [WIDTH-1:0] reg_q;
    logic             reg_c, reg_ovf, reg_zero;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_c, rsp_ovf, rsp_zero, rsp_timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .reg_en(reg_en), .reg_q(reg_q),
        .reg_c(reg_c), .reg_ovf(reg_ovf), .reg_zero(reg_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_c(rsp_c), .rsp_ovf(rsp_ovf),
        .rsp_zero(rsp_zero), .rsp_timeout(rsp_timeout)
    );

    // Shared ALU + result register: op 0 adds, anything else subtracts.
    always @(posedge clk or posedge rst) begin
        if (rst)
            reg_q <= '0;
        else if (reg_en)
            reg_q <= (alu_op == 0) ? alu_a + alu_b : alu_a - alu_b;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        reg_c = 1'b0; reg_ovf = 1'b0; reg_zero = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_reg_en", reg_en, 0);
        chk("rst_alu_a", alu_a, 0);
        tick();
        tick();
        rst = 1'b0;

        // Single request: 5 + 3
        req0_a = 5; req0_b = 3; req0_op = 0;
        #1;
        chk("n_ready0", req0_ready, 1);
        chk("n_ready1", req1_ready, 0);
        chk("n_reg_en", reg_en, 0);
        tick();
        #1;
        chk("n1_reg_en", reg_en, 1);
        chk("n1_alu_a", alu_a, 5);
        chk("n1_alu_b", alu_b, 3);
        chk("n1_alu_op", alu_op, 0);
        chk("n1_ready0", req0_ready, 0);
        chk("n1_rsp_valid", rsp_valid, 0);
        req0_valid = 1'b0;
        tick();
        #1;
        chk("n2_rsp_valid", rsp_valid, 1);
        chk("n2_reg_en", reg_en, 0);
        chk("n2_rsp_id", rsp_id, 0);
        chk("n2_rsp_data", rsp_data, 8);
        chk("n2_alu_a", alu_a, 5);
        rsp_ready = 1'b1;
        tick();
        #1;
        chk("n3_rsp_valid", rsp_valid, 0);

        // Round-robin from a fresh reset
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 1;  req0_b = 1; req0_op = 0;
        req1_valid = 1'b1; req1_a = 10; req1_b = 2; req1_op = 1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", req0_ready, (i % 2) == 0);
            chk("rr_ready1", req1_ready, (i % 2) == 1);
            tick();
            tick();
            #1;
            chk("rr_rsp_id", rsp_id, i % 2);
            chk("rr_rsp_data", rsp_data, (i % 2) ? 8 : 2);
            chk("rr_busy_ready0", req0_ready, 0);
            chk("rr_busy_ready1", req1_ready, 0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure hold with flags: 7 - 2 from req1
        req1_valid = 1'b1; req1_a = 7; req1_b = 2; req1_op = 1;
        rsp_ready = 1'b0;
        reg_c = 1'b1; reg_ovf = 1'b1; reg_zero = 1'b0;
        #1;
        chk("bp_ready1", req1_ready, 1);
        chk("bp_ready0", req0_ready, 0);
        tick();
        req1_valid = 1'b0; req0_valid = 1'b1;
        #1;
        chk("bp_exec_ready0", req0_ready, 0);
        chk("bp_exec_op", alu_op, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 5);
            chk("bp_rsp_id", rsp_id, 1);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            chk("bp_rsp_c", rsp_c, 1);
            chk("bp_rsp_ovf", rsp_ovf, 1);
            chk("bp_rsp_zero", rsp_zero, 0);
            if (i < 4) tick();
        end
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        #1;
        chk("bp_done_valid", rsp_valid, 0);
        reg_c = 1'b0; reg_ovf = 1'b0;

        // Stalled response: 4 + 4 from req0
        req0_valid = 1'b1; req0_a = 4; req0_b = 4; req0_op = 0;
        rsp_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        #1;
        chk("to_rsp_data", rsp_data, 8);
`ifdef ALU_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            chk("to_wait_valid", rsp_valid, 1);
            chk("to_wait_pulse", rsp_timeout, 0);
            tick();
            #1;
        end
        chk("to_pulse", rsp_timeout, 1);
        chk("to_dropped", rsp_valid, 0);
        tick();
        #1;
        chk("to_pulse_end", rsp_timeout, 0);
`else
        for (int i = 0; i < 100; i++) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_timeout", rsp_timeout, 0);
            tick();
            #1;
        end
        rsp_ready = 1'b1;
        tick();
        #1;
        chk("hold_done", rsp_valid, 0);
`endif

        // Reset during EXEC abandons the operation
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 9; req0_b = 9; req0_op = 0;
        tick();
        req0_valid = 1'b0;
        #1;
        chk("rx_exec_reg_en", reg_en, 1);
        rst = 1'b1;
        #1;
        chk("rx_reg_en", reg_en, 0);
        chk("rx_alu_a", alu_a, 0);
        chk("rx_rsp_valid", rsp_valid, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rx_post_valid", rsp_valid, 0);
            chk("rx_post_reg_en", reg_en, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
